vram_scan_arbiter: RTL and testbench

- Owns the single-port framebuffer RAM. Shares it between the VGA scan-out path, which reads, and the renderer, which writes.
- Scan-out reads use the timing generator's valid/h_cnt/v_cnt and have absolute priority. The renderer gets every other cycle.
- Double-buffers a 320x240, 8bpp image, pixel-doubled to 640x480. The front/back swap is deferred to the vsync leading edge, so frames never tear.

---
 rtl/vram_scan_arbiter.sv | 152 +++++++++++++++
 tb/tb_vram_scan_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/vram_scan_arbiter.sv
// vram_scan_arbiter: shares one single-port framebuffer RAM between VGA
// scan-out reads and renderer writes. Scan-out reads always take the cycle.
// The front/back buffer swap waits for the vsync leading edge so that frames
// never tear. The image is 320x240, 8bpp, and is pixel-doubled to 640x480.
module vram_scan_arbiter #(
  parameter int FB_W      = 320,
  parameter int FB_H      = 240,
  parameter int BUF_WORDS = FB_W * FB_H,
  parameter int AW        = 18,
  parameter int DW        = 8
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          valid,
  input  logic [9:0]    h_cnt,
  input  logic [9:0]    v_cnt,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          wr_req,
  input  logic [16:0]   wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          swap_req,
  output logic          swap_done,
  output logic          front_buf,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] rgb_out,
  output logic          hsync_out,
  output logic          vsync_out,
  output logic          valid_out
);

  localparam logic [1:0] ST_RUN       = 2'd0;
  localparam logic [1:0] ST_WAIT_SWAP = 2'd1;

  localparam logic [AW-1:0] BUF_BASE = AW'(BUF_WORDS);

  logic [1:0]    state_reg;
  logic          front_buf_reg;
  logic          swap_done_reg;
  logic          vsync_hist_reg;
  logic [AW-1:0] addr_hold_reg;
  logic          rd_pend_reg;
  logic [DW-1:0] pix_reg;
  logic [1:0]    valid_d_reg;
  logic [1:0]    hsync_d_reg;
  logic [1:0]    vsync_d_reg;

  logic          display_slot;
  logic          vsync_fall;
  logic [9:0]    v_half;
  logic [9:0]    h_half;
  logic [AW-1:0] row_offset;
  logic [AW-1:0] disp_addr;
  logic [AW-1:0] back_addr;
  logic          wr_in_range;

  // Even columns of active video are scan-out reads; every other cycle
  // belongs to the renderer.
  assign display_slot = valid && !h_cnt[0];
  assign vsync_fall   = vsync_hist_reg && !vsync_in;

  // Each framebuffer pixel covers a 2x2 block of screen pixels. The row
  // multiply by 320 is done as (v<<8)+(v<<6) so that it stays combinational.
  assign v_half     = v_cnt >> 1;
  assign h_half     = h_cnt >> 1;
  assign row_offset = (AW'(v_half) << 8) + (AW'(v_half) << 6);
  assign disp_addr  = (front_buf_reg ? BUF_BASE : '0) + row_offset + AW'(h_half);
  assign back_addr  = (front_buf_reg ? '0 : BUF_BASE) + AW'(wr_addr);
  assign wr_in_range = AW'(wr_addr) < BUF_BASE;

  // An out-of-range write is still acked so the renderer moves on; only the
  // write enable is suppressed.
  assign wr_ack = wr_req && !display_slot && (state_reg == ST_RUN) && !reset;

  // RAM port mux: display read, renderer write, or hold the last address.
  always_comb begin
    mem_addr  = addr_hold_reg;
    mem_we    = 1'b0;
    mem_wdata = wr_data;
    if (display_slot) begin
      mem_addr = disp_addr;
    end else if (wr_ack) begin
      mem_addr = back_addr;
      mem_we   = wr_in_range;
    end
  end

  // Remember the last address driven so that idle cycles do not toggle the bus.
  always_ff @(posedge pclk) begin
    if (reset) addr_hold_reg <= '0;
    else       addr_hold_reg <= mem_addr;
  end

  // Swap FSM: arm on swap_req, then flip the buffers at the next vsync
  // leading edge.
  always_ff @(posedge pclk) begin
    if (reset) begin
      state_reg      <= ST_RUN;
      front_buf_reg  <= 1'b0;
      swap_done_reg  <= 1'b0;
      vsync_hist_reg <= 1'b1;
    end else begin
      swap_done_reg  <= 1'b0;
      vsync_hist_reg <= vsync_in;
      case (state_reg)
        ST_RUN: begin
          if (swap_req) state_reg <= ST_WAIT_SWAP;
        end
        ST_WAIT_SWAP: begin
          if (vsync_fall) begin
            front_buf_reg <= ~front_buf_reg;
            swap_done_reg <= 1'b1;
            state_reg     <= ST_RUN;
          end
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  // Scan-out pipeline: the read data arrives one cycle after the read is
  // issued and is captured into the pixel register one cycle later. The
  // pixel register holds across the odd column, which doubles the pixel
  // horizontally. The syncs and valid are delayed by two cycles to match.
  always_ff @(posedge pclk) begin
    if (reset) begin
      rd_pend_reg <= 1'b0;
      pix_reg     <= '0;
      valid_d_reg <= 2'b00;
      hsync_d_reg <= 2'b11;
      vsync_d_reg <= 2'b11;
    end else begin
      rd_pend_reg <= display_slot;
      if (rd_pend_reg) pix_reg <= mem_rdata;
      valid_d_reg <= {valid_d_reg[0], valid};
      hsync_d_reg <= {hsync_d_reg[0], hsync_in};
      vsync_d_reg <= {vsync_d_reg[0], vsync_in};
    end
  end

  assign rgb_out   = valid_d_reg[1] ? pix_reg : '0;
  assign valid_out = valid_d_reg[1];
  assign hsync_out = hsync_d_reg[1];
  assign vsync_out = vsync_d_reg[1];
  assign front_buf = front_buf_reg;
  assign swap_done = swap_done_reg;

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Testbench for vram_scan_arbiter. A behavioural RAM with a registered read
// sits on the memory port. A reference model checks the RAM port and the
// swap outputs every cycle. A scoreboard queue holds the scan-out outputs
// that are expected two cycles later.
module tb_vram_scan_arbiter;
  localparam int BW = 76800;

  logic        pclk = 1'b0;
  logic        reset;
  logic        valid;
  logic [9:0]  h_cnt, v_cnt;
  logic        hsync_in, vsync_in;
  logic        wr_req;
  logic [16:0] wr_addr;
  logic [7:0]  wr_data;
  logic        wr_ack;
  logic        swap_req, swap_done, front_buf;
  logic [17:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [7:0]  rgb_out;
  logic        hsync_out, vsync_out, valid_out;

  always #5 pclk = ~pclk;

  vram_scan_arbiter dut (
    .pclk(pclk), .reset(reset), .valid(valid), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_ack(wr_ack), .swap_req(swap_req), .swap_done(swap_done),
    .front_buf(front_buf), .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rgb_out(rgb_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .valid_out(valid_out)
  );

  // Single-port RAM with a one-cycle registered read
  logic [7:0] ram    [0:2*BW-1];
  logic [7:0] shadow [0:2*BW-1];
  always @(posedge pclk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  int checks = 0;
  int passes = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
  endtask

  typedef struct {
    logic [7:0] rgb;
    logic       hs;
    logic       vs;
    logic       vld;
  } exp_t;
  exp_t sb_q[$];

  // Reference model state
  logic        m_front, m_wait, m_vs_hist, m_swap_done;
  logic [17:0] m_hold;
  logic [7:0]  m_pix;

  // One clock cycle: check the outputs against the model, then advance the model across the edge
  task automatic tick();
    logic disp, ack, we;
    logic [17:0] addr;
    int a;
    exp_t e, o;
    #1;
    disp = valid && !h_cnt[0];
    ack  = wr_req && !disp && !m_wait && !reset;
    we   = ack && (int'(wr_addr) < BW);
    if (disp)     a = (m_front ? BW : 0) + int'(v_cnt / 2) * 320 + int'(h_cnt / 2);
    else if (ack) a = (m_front ? 0 : BW) + int'(wr_addr);
    else          a = int'(m_hold);
    addr = 18'(a);
    check_eq("wr_ack", wr_ack, ack);
    check_eq("mem_we", mem_we, we);
    if (!reset) begin
      check_eq("mem_addr", mem_addr, addr);
      if (we) check_eq("mem_wdata", mem_wdata, wr_data);
      check_eq("front_buf", front_buf, m_front);
      check_eq("swap_done", swap_done, m_swap_done);
    end
    if (sb_q.size() > 0) begin
      o = sb_q.pop_front();
      check_eq("rgb_out", rgb_out, o.rgb);
      check_eq("hsync_out", hsync_out, o.hs);
      check_eq("vsync_out", vsync_out, o.vs);
      check_eq("valid_out", valid_out, o.vld);
    end
    if (disp) m_pix = shadow[addr];
    e.rgb = valid ? m_pix : 8'h00;
    e.hs  = hsync_in;
    e.vs  = vsync_in;
    e.vld = valid;
    if (!reset) sb_q.push_back(e);
    @(posedge pclk);
    if (reset) begin
      m_front = 0; m_wait = 0; m_vs_hist = 1; m_swap_done = 0; m_hold = '0; m_pix = 8'h00;
      sb_q.delete();
      e.rgb = 8'h00; e.hs = 1'b1; e.vs = 1'b1; e.vld = 1'b0;
      sb_q.push_back(e);
      sb_q.push_back(e);
    end else begin
      if (we) shadow[addr] = wr_data;
      m_hold = addr;
      m_swap_done = m_wait && m_vs_hist && !vsync_in;
      if (m_wait) begin
        if (m_vs_hist && !vsync_in) begin
          m_front = !m_front;
          m_wait  = 0;
        end
      end else if (swap_req) begin
        m_wait = 1;
      end
      m_vs_hist = vsync_in;
    end
    #1;
  endtask

  // Active columns h0..h1-1 of line v, followed by a short hsync blanking burst
  task automatic run_line(input int v, input int h0, input int h1, input int swap_at, input int rst_at);
    for (int h = h0; h < h1; h++) begin
      valid = 1'b1; h_cnt = 10'(h); v_cnt = 10'(v);
      swap_req = (h == swap_at);
      reset    = (h == rst_at);
      tick();
    end
    valid = 1'b0; swap_req = 1'b0; reset = 1'b0;
    hsync_in = 1'b0;
    repeat (3) tick();
    hsync_in = 1'b1;
    repeat (2) tick();
  endtask

  initial begin
    for (int k = 0; k < 2 * BW; k++) begin
      ram[k]    = 8'(k);
      shadow[k] = 8'(k);
    end
    m_front = 0; m_wait = 0; m_vs_hist = 1; m_swap_done = 0; m_hold = '0; m_pix = 8'h00;
    valid = 0; h_cnt = 0; v_cnt = 0; hsync_in = 1; vsync_in = 1;
    wr_req = 0; wr_addr = 0; wr_data = 0; swap_req = 0;
    reset = 1;
    @(posedge pclk); #1;
    tick(); tick();
    reset = 0;
    tick(); tick();
    check_eq("reset_front_buf", front_buf, 1'b0);
    check_eq("reset_rgb_out", rgb_out, 8'h00);

    // First active line: rgb 00,00,01,01,...
    run_line(0, 0, 16, -1, -1);

    // Renderer holds a request through an active line; it is acked on odd columns only
    wr_req = 1; wr_addr = 17'd5; wr_data = 8'hA5;
    run_line(2, 0, 8, -1, -1);
    wr_req = 0;

    // Out-of-range write during blanking is acked but dropped
    wr_req = 1; wr_addr = 17'(BW); wr_data = 8'hFF;
    tick();
    wr_req = 0;
    tick();
    check_eq("oob_ram_unchanged", ram[BW], 8'h00);
    check_eq("ram_back5", ram[BW + 5], 8'hA5);

    wr_req = 1; wr_addr = 17'd1; wr_data = 8'h3C;
    tick();
    wr_req = 0;
    tick();

    // swap_req at line 100 stalls the renderer until the vsync edge
    wr_req = 1; wr_addr = 17'd0; wr_data = 8'h77;
    run_line(100, 0, 8, 0, -1);
    vsync_in = 0;
    repeat (3) tick();
    vsync_in = 1;
    check_eq("front_after_swap", front_buf, 1'b1);
    repeat (2) tick();
    wr_req = 0;
    tick();
    check_eq("ram_front0_written", ram[0], 8'h77);

    // Scan-out now reads from buffer 1 (base 76800)
    run_line(0, 0, 12, -1, -1);

    // swap_req together with a vsync edge: no swap in this frame
    swap_req = 1; vsync_in = 0;
    tick();
    swap_req = 0;
    tick(); tick();
    vsync_in = 1;
    repeat (3) tick();
    check_eq("coincident_no_swap", front_buf, 1'b1);
    run_line(0, 0, 4, -1, -1);
    vsync_in = 0;
    repeat (3) tick();
    vsync_in = 1;
    repeat (2) tick();
    check_eq("swap_next_frame", front_buf, 1'b0);

    // Reset in the middle of a line while a swap is pending
    swap_req = 1;
    tick();
    swap_req = 0;
    wr_req = 1; wr_addr = 17'd9; wr_data = 8'h5A;
    run_line(10, 296, 308, -1, 300);
    wr_req = 0;
    vsync_in = 0;
    repeat (3) tick();
    vsync_in = 1;
    repeat (3) tick();
    check_eq("reset_discarded_swap", front_buf, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
